// File: rtl/lc3_fetch_pkg.sv
// Shared types, reset constant and next-PC rule for the LC3 fetch stage.
package lc3_fetch_pkg;

    typedef logic [15:0] lc3_word_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } fetch_state_t;

    localparam lc3_word_t LC3_RESET_PC = 16'h3000;

    // Sequential advance wraps modulo 2^16, so 16'hFFFF steps to 16'h0000.
    function automatic lc3_word_t next_pc(
        input lc3_word_t pc,
        input logic      br_taken,
        input lc3_word_t taddr
    );
        return br_taken ? taddr : lc3_word_t'(pc + 16'd1);
    endfunction

endpackage

// File: rtl/lc3_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface lc3_fetch_stage_if;
    import lc3_fetch_pkg::*;

    logic      imem_rd;
    lc3_word_t imem_addr;
    lc3_word_t imem_rdata;
    logic      imem_rvalid;

    modport master (
        output imem_rd,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_rd,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );

endinterface

// File: rtl/lc3_pc_reg.sv
// Program counter with the sequential / branch-target select in front of it.
module lc3_pc_reg
    import lc3_fetch_pkg::*;
#(
    parameter lc3_word_t RESET_PC = LC3_RESET_PC
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      enable_update_pc,
    input  logic      br_taken,
    input  lc3_word_t taddr,
    output lc3_word_t pc
);

    lc3_word_t pc_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (enable_update_pc) begin
            pc_reg <= next_pc(pc_reg, br_taken, taddr);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/lc3_fetch_stage.sv
// LC3 fetch stage: single-outstanding instruction reads, capture into decode
// registers, redirect-aware discard and a sticky fetch timeout.
module lc3_fetch_stage
    import lc3_fetch_pkg::*;
#(
    parameter lc3_word_t   RESET_PC = LC3_RESET_PC,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable_fetch,
    input  logic                      enable_update_pc,
    input  logic                      br_taken,
    input  lc3_word_t                 taddr,
    lc3_fetch_stage_if.master         imem,
    output lc3_word_t                 pc,
    output lc3_word_t                 dout,
    output lc3_word_t                 npc_out,
    output logic                      enable_decode,
    output logic                      fetch_err
);

    // Last WAIT cycle index before the fetch is declared lost.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t state_reg,         state_next;
    logic         flush_reg,         flush_next;
    logic [7:0]   wait_cnt_reg,      wait_cnt_next;
    lc3_word_t    req_addr_reg,      req_addr_next;
    lc3_word_t    dout_reg,          dout_next;
    lc3_word_t    npc_reg,           npc_next;
    logic         enable_decode_reg, enable_decode_next;
    logic         fetch_err_reg,     fetch_err_next;

    lc3_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock            (clock),
        .reset            (reset),
        .enable_update_pc (enable_update_pc),
        .br_taken         (br_taken),
        .taddr            (taddr),
        .pc               (pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            flush_reg         <= 1'b0;
            wait_cnt_reg      <= 8'd0;
            req_addr_reg      <= RESET_PC;
            dout_reg          <= 16'h0000;
            npc_reg           <= 16'h0000;
            enable_decode_reg <= 1'b0;
            fetch_err_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            flush_reg         <= flush_next;
            wait_cnt_reg      <= wait_cnt_next;
            req_addr_reg      <= req_addr_next;
            dout_reg          <= dout_next;
            npc_reg           <= npc_next;
            enable_decode_reg <= enable_decode_next;
            fetch_err_reg     <= fetch_err_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        flush_next         = flush_reg;
        wait_cnt_next      = wait_cnt_reg;
        req_addr_next      = req_addr_reg;
        dout_next          = dout_reg;
        npc_next           = npc_reg;
        enable_decode_next = 1'b0;
        fetch_err_next     = fetch_err_reg;
        imem.imem_rd       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fetch_err_reg && enable_fetch) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                imem.imem_rd  = 1'b1;
                req_addr_next = pc;
                flush_next    = 1'b0;
                wait_cnt_next = 8'd0;
                state_next    = WAIT;
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    // A redirect since the request makes this word stale; refetch at the new pc.
                    if (flush_reg || enable_update_pc) begin
                        state_next = REQ;
                    end else begin
                        dout_next          = imem.imem_rdata;
                        npc_next           = lc3_word_t'(req_addr_reg + 16'd1);
                        enable_decode_next = 1'b1;
                        state_next         = DONE;
                    end
                end else begin
                    if (enable_update_pc) begin
                        flush_next = 1'b1;
                    end
                    if (wait_cnt_reg == WAIT_LAST) begin
                        fetch_err_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end
            end
            DONE: begin
                state_next = enable_fetch ? REQ : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem.imem_addr = pc;
    assign dout           = dout_reg;
    assign npc_out        = npc_reg;
    assign enable_decode  = enable_decode_reg;
    assign fetch_err      = fetch_err_reg;

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// Self-checking bench for lc3_fetch_stage: directed scenarios plus a randomized
// run scored against a transaction-level model of fetches and PC updates.
module tb_lc3_fetch_stage;

    localparam int MAX_WAIT = 8;

    logic        clock;
    logic        reset;
    logic        enable_fetch;
    logic        enable_update_pc;
    logic        br_taken;
    logic [15:0] taddr;
    logic [15:0] pc;
    logic [15:0] dout;
    logic [15:0] npc_out;
    logic        enable_decode;
    logic        fetch_err;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    lc3_fetch_stage_if imem ();

    lc3_fetch_stage #(
        .RESET_PC (16'h3000),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable_fetch     (enable_fetch),
        .enable_update_pc (enable_update_pc),
        .br_taken         (br_taken),
        .taddr            (taddr),
        .imem             (imem),
        .pc               (pc),
        .dout             (dout),
        .npc_out          (npc_out),
        .enable_decode    (enable_decode),
        .fetch_err        (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic ef, input logic eup, input logic br,
                         input logic [15:0] ta, input logic rv, input logic [15:0] rdat);
        enable_fetch     = ef;
        enable_update_pc = eup;
        br_taken         = br;
        taddr            = ta;
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rdat;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1, 1, 1, 16'h1111, 1, 16'h2222);
        tick;
        tick;
        compared++; if (pc !== 16'h3000) begin mismatched++; $display("FAIL reset_pc: got %h expected 3000", pc); end
        compared++; if (imem.imem_addr !== 16'h3000) begin mismatched++; $display("FAIL reset_addr: got %h expected 3000", imem.imem_addr); end
        compared++; if (imem.imem_rd !== 1'b0) begin mismatched++; $display("FAIL reset_rd: got %b expected 0", imem.imem_rd); end
        compared++; if (dout !== 16'h0000) begin mismatched++; $display("FAIL reset_dout: got %h expected 0000", dout); end
        compared++; if (npc_out !== 16'h0000) begin mismatched++; $display("FAIL reset_npc: got %h expected 0000", npc_out); end
        compared++; if (enable_decode !== 1'b0) begin mismatched++; $display("FAIL reset_dec: got %b expected 0", enable_decode); end
        compared++; if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
        reset = 1'b0;
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_basic_fetch;
        int rd_cyc;
        do_reset();
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        tick;
        compared++; if (imem.imem_rd !== 1'b1 || imem.imem_addr !== 16'h3000) begin mismatched++; $display("FAIL basic_req: got rd=%b addr=%h expected rd=1 addr=3000", imem.imem_rd, imem.imem_addr); end
        rd_cyc = cyc;
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        tick;
        compared++; if (enable_decode !== 1'b0) begin mismatched++; $display("FAIL basic_early_dec: got %b expected 0", enable_decode); end
        drive(0, 0, 0, 16'h0, 1, 16'h1234);
        tick;
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        compared++; if (enable_decode !== 1'b1 || cyc - rd_cyc != 2) begin mismatched++; $display("FAIL basic_dec: got dec=%b lat=%0d expected dec=1 lat=2", enable_decode, cyc - rd_cyc); end
        compared++; if (dout !== 16'h1234 || npc_out !== 16'h3001) begin mismatched++; $display("FAIL basic_data: got dout=%h npc=%h expected 1234 3001", dout, npc_out); end
        tick;
        compared++; if (enable_decode !== 1'b0 || dout !== 16'h1234 || imem.imem_rd !== 1'b0) begin mismatched++; $display("FAIL basic_after: got dec=%b dout=%h rd=%b expected 0 1234 0", enable_decode, dout, imem.imem_rd); end
        $display("test_basic_fetch done at cycle %0d", cyc);
    endtask

    task automatic test_back_to_back;
        int prev;
        prev = -1;
        do_reset();
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6 && imem.imem_rd !== 1'b1; i++) tick;
            compared++; if (imem.imem_rd !== 1'b1 || imem.imem_addr !== 16'(16'h3000 + k)) begin mismatched++; $display("FAIL b2b_addr%0d: got rd=%b addr=%h expected rd=1 addr=%h", k, imem.imem_rd, imem.imem_addr, 16'(16'h3000 + k)); end
            if (k > 0) begin
                compared++; if (cyc - prev != 3) begin mismatched++; $display("FAIL b2b_period%0d: got %0d expected 3", k, cyc - prev); end
            end
            prev = cyc;
            drive(1, 0, 0, 16'h0, 0, 16'h0);
            tick;
            drive(1, 0, 0, 16'h0, 1, 16'(16'h5000 + k));
            tick;
            compared++; if (enable_decode !== 1'b1 || dout !== 16'(16'h5000 + k) || npc_out !== 16'(16'h3001 + k)) begin mismatched++; $display("FAIL b2b_data%0d: got dec=%b dout=%h npc=%h expected 1 %h %h", k, enable_decode, dout, npc_out, 16'(16'h5000 + k), 16'(16'h3001 + k)); end
            drive(1, 1, 0, 16'h0, 0, 16'h0);
            tick;
            drive(1, 0, 0, 16'h0, 0, 16'h0);
        end
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        $display("test_back_to_back done at cycle %0d", cyc);
    endtask

    task automatic test_branch_flush;
        do_reset();
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        tick;
        compared++; if (imem.imem_rd !== 1'b1 || imem.imem_addr !== 16'h3000) begin mismatched++; $display("FAIL flush_req: got rd=%b addr=%h expected 1 3000", imem.imem_rd, imem.imem_addr); end
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        tick;
        drive(1, 1, 1, 16'h4050, 0, 16'h0);
        tick;
        drive(1, 0, 0, 16'h0, 1, 16'hDEAD);
        tick;
        compared++; if (enable_decode !== 1'b0) begin mismatched++; $display("FAIL flush_discard: got dec=%b expected 0", enable_decode); end
        compared++; if (imem.imem_rd !== 1'b1 || imem.imem_addr !== 16'h4050) begin mismatched++; $display("FAIL flush_refetch: got rd=%b addr=%h expected 1 4050", imem.imem_rd, imem.imem_addr); end
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        tick;
        drive(0, 0, 0, 16'h0, 1, 16'h7777);
        tick;
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        compared++; if (enable_decode !== 1'b1 || dout !== 16'h7777 || npc_out !== 16'h4051) begin mismatched++; $display("FAIL flush_deliver: got dec=%b dout=%h npc=%h expected 1 7777 4051", enable_decode, dout, npc_out); end
        $display("test_branch_flush done at cycle %0d", cyc);
    endtask

    task automatic test_pc_wrap;
        do_reset();
        drive(0, 1, 1, 16'hFFFF, 0, 16'h0);
        tick;
        compared++; if (pc !== 16'hFFFF) begin mismatched++; $display("FAIL wrap_jump: got %h expected ffff", pc); end
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        tick;
        compared++; if (imem.imem_rd !== 1'b1 || imem.imem_addr !== 16'hFFFF) begin mismatched++; $display("FAIL wrap_req: got rd=%b addr=%h expected 1 ffff", imem.imem_rd, imem.imem_addr); end
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        tick;
        drive(0, 0, 0, 16'h0, 1, 16'h0F0F);
        tick;
        compared++; if (enable_decode !== 1'b1 || dout !== 16'h0F0F || npc_out !== 16'h0000) begin mismatched++; $display("FAIL wrap_npc: got dec=%b dout=%h npc=%h expected 1 0f0f 0000", enable_decode, dout, npc_out); end
        drive(0, 1, 0, 16'h0, 0, 16'h0);
        tick;
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        compared++; if (pc !== 16'h0000) begin mismatched++; $display("FAIL wrap_pc: got %h expected 0000", pc); end
        $display("test_pc_wrap done at cycle %0d", cyc);
    endtask

    task automatic test_timeout;
        int rd_cyc;
        do_reset();
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        tick;
        compared++; if (imem.imem_rd !== 1'b1) begin mismatched++; $display("FAIL timeout_req: got rd=%b expected 1", imem.imem_rd); end
        rd_cyc = cyc;
        for (int i = 0; i < 20 && fetch_err !== 1'b1; i++) tick;
        compared++; if (fetch_err !== 1'b1 || cyc - rd_cyc != MAX_WAIT + 1) begin mismatched++; $display("FAIL timeout_err: got err=%b after=%0d expected err=1 after=%0d", fetch_err, cyc - rd_cyc, MAX_WAIT + 1); end
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 16'h0, 1, 16'($urandom));
            tick;
            compared++; if (imem.imem_rd !== 1'b0 || enable_decode !== 1'b0 || fetch_err !== 1'b1) begin mismatched++; $display("FAIL timeout_stuck%0d: got rd=%b dec=%b err=%b expected 0 0 1", i, imem.imem_rd, enable_decode, fetch_err); end
        end
        do_reset();
        compared++; if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL timeout_clear: got %b expected 0", fetch_err); end
        $display("test_timeout done at cycle %0d", cyc);
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        drive(0, 1, 0, 16'h0, 0, 16'h0);
        tick;
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        tick;
        compared++; if (imem.imem_rd !== 1'b1 || imem.imem_addr !== 16'h3001) begin mismatched++; $display("FAIL rstwait_req: got rd=%b addr=%h expected 1 3001", imem.imem_rd, imem.imem_addr); end
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive(0, 0, 0, 16'h0, 1, 16'hBEEF);
        tick;
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        compared++; if (enable_decode !== 1'b0 || dout !== 16'h0000 || pc !== 16'h3000) begin mismatched++; $display("FAIL rstwait_state: got dec=%b dout=%h pc=%h expected 0 0000 3000", enable_decode, dout, pc); end
        tick;
        compared++; if (enable_decode !== 1'b0 || dout !== 16'h0000) begin mismatched++; $display("FAIL rstwait_late: got dec=%b dout=%h expected 0 0000", enable_decode, dout); end
        $display("test_reset_mid_wait done at cycle %0d", cyc);
    endtask

    task automatic test_random;
        logic        pending, tainted, rd_now, exp_dec, eup, br, rv;
        logic [15:0] pend_addr, model_pc, exp_dout, exp_npc, last_dout, last_npc, ta, rdat;
        int          lat, fetches;
        do_reset();
        model_pc  = 16'h3000;
        pending   = 1'b0;
        tainted   = 1'b0;
        exp_dec   = 1'b0;
        exp_dout  = 16'h0;
        exp_npc   = 16'h0;
        pend_addr = 16'h0;
        last_dout = 16'h0;
        last_npc  = 16'h0;
        lat       = 0;
        fetches   = 0;
        for (int c = 0; c < 1200; c++) begin
            compared++; if (enable_decode !== exp_dec) begin mismatched++; $display("FAIL rnd_dec c%0d: got %b expected %b", c, enable_decode, exp_dec); end
            if (exp_dec) begin
                last_dout = exp_dout;
                last_npc  = exp_npc;
            end
            compared++; if (dout !== last_dout || npc_out !== last_npc) begin mismatched++; $display("FAIL rnd_data c%0d: got %h/%h expected %h/%h", c, dout, npc_out, last_dout, last_npc); end
            compared++; if (pc !== model_pc) begin mismatched++; $display("FAIL rnd_pc c%0d: got %h expected %h", c, pc, model_pc); end
            compared++; if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL rnd_err c%0d: got %b expected 0", c, fetch_err); end
            rd_now = imem.imem_rd;
            if (rd_now) begin
                compared++; if (pending) begin mismatched++; $display("FAIL rnd_overlap c%0d: got rd=1 expected no read while outstanding", c); end
                compared++; if (imem.imem_addr !== model_pc) begin mismatched++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, imem.imem_addr, model_pc); end
                pending   = 1'b1;
                pend_addr = model_pc;
                tainted   = 1'b0;
                lat       = $urandom_range(1, 3);
                fetches++;
            end
            eup          = ($urandom_range(0, 5) == 0);
            br           = 1'($urandom_range(0, 1));
            ta           = 16'($urandom);
            rdat         = 16'($urandom);
            enable_fetch = ($urandom_range(0, 4) != 0);
            rv           = 1'b0;
            exp_dec      = 1'b0;
            if (pending && !rd_now) begin
                lat--;
                if (lat == 0) begin
                    rv      = 1'b1;
                    pending = 1'b0;
                    if (!(tainted || eup)) begin
                        exp_dec  = 1'b1;
                        exp_dout = rdat;
                        exp_npc  = 16'(pend_addr + 16'd1);
                    end
                end else if (eup) begin
                    tainted = 1'b1;
                end
            end else begin
                rv = ($urandom_range(0, 3) == 0);
            end
            enable_update_pc = eup;
            br_taken         = br;
            taddr            = ta;
            imem.imem_rvalid = rv;
            imem.imem_rdata  = rdat;
            if (eup) model_pc = br ? ta : 16'(model_pc + 16'd1);
            tick;
        end
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        compared++; if (fetches < 80) begin mismatched++; $display("FAIL rnd_progress: got %0d fetches expected at least 80", fetches); end
        $display("test_random done at cycle %0d with %0d fetches", cyc, fetches);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_branch_flush();
        test_pc_wrap();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
